// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM state type and the ALU opcode -> control-word table function.
// Latency: n/a (package). Backpressure: n/a.
// The table function is the single source of truth shared with the forward decoder ROM.
package alu_ctrl_pkg;

    localparam int CTRL_W = 8;
    localparam int OPC_W  = 4;
    localparam int DEPTH  = 16;

    // Last index scanned; the search stops here instead of wrapping.
    localparam logic [OPC_W-1:0] IDX_LAST = OPC_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Opcodes 0..13 map to a regular pattern; 14 and 15 are special-cased words.
    function automatic logic [CTRL_W-1:0] alu_ctrl_word(input logic [OPC_W-1:0] opcode);
        logic [CTRL_W-1:0] word;
        case (opcode)
            4'd14:   word = 8'hF9;
            4'd15:   word = 8'hFD;
            default: word = {2'b00, opcode, 2'b01};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/alu_ctrl_table.sv
// Combinational index -> control word lookup over the shared decode table.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns sequencing.
module alu_ctrl_table
    import alu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0]  idx,
    output logic [CTRL_W-1:0] ctrl_word
);

    // Table contents come from the shared function so encoder and decoder never diverge.
    always_comb begin
        ctrl_word = alu_ctrl_word(idx);
    end

endmodule

// File: rtl/alu_ctrl_encoder.sv
// Reverse ALU decoder: finds the opcode whose control word equals the request, one entry per cycle.
// Latency: hit at entry k -> rsp_valid k+2 edges after accept; miss -> 17 edges (cache hit: 1 edge).
// Backpressure: req_ready low outside IDLE; response held stable until rsp_ready. Option macro: ALU_CTRL_ENC_LASTHIT_EN.
module alu_ctrl_encoder
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CTRL_W-1:0] req_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OPC_W-1:0]  rsp_opcode,
    output logic              rsp_hit
);

    state_t              state_q, state_d;
    logic [OPC_W-1:0]    idx_q, idx_d;
    logic [CTRL_W-1:0]   word_q, word_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [OPC_W-1:0]    rsp_opcode_q, rsp_opcode_d;
    logic                rsp_hit_q, rsp_hit_d;

    logic [CTRL_W-1:0]   table_word;
    logic                entry_match;
    logic                accept;

    alu_ctrl_table u_table (
        .idx       (idx_q),
        .ctrl_word (table_word)
    );

    assign entry_match = (word_q == table_word);
    assign accept      = req_valid && req_ready_q;

`ifdef ALU_CTRL_ENC_LASTHIT_EN
    logic                cache_vld_q, cache_vld_d;
    logic [CTRL_W-1:0]   cache_ctrl_q, cache_ctrl_d;
    logic [OPC_W-1:0]    cache_opc_q, cache_opc_d;
    logic                cache_hit;

    assign cache_hit = cache_vld_q && (req_ctrl == cache_ctrl_q);
`endif

    // Next-state and next-output computation for the scan FSM (and the last-hit cache when built).
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_hit_d    = rsp_hit_q;
`ifdef ALU_CTRL_ENC_LASTHIT_EN
        cache_vld_d  = cache_vld_q;
        cache_ctrl_d = cache_ctrl_q;
        cache_opc_d  = cache_opc_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d      = req_ctrl;
                    idx_d       = '0;
                    req_ready_d = 1'b0;
`ifdef ALU_CTRL_ENC_LASTHIT_EN
                    if (cache_hit) begin
                        // Repeat of the last hit: answer straight away, no scan.
                        rsp_opcode_d = cache_opc_q;
                        rsp_hit_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = SEARCH;
                    end
`else
                    state_d = SEARCH;
`endif
                end
            end
            SEARCH: begin
                if (entry_match) begin
                    rsp_opcode_d = idx_q;
                    rsp_hit_d    = 1'b1;
                    state_d      = RESP;
`ifdef ALU_CTRL_ENC_LASTHIT_EN
                    cache_vld_d  = 1'b1;
                    cache_ctrl_d = word_q;
                    cache_opc_d  = idx_q;
`endif
                end else if (idx_q == IDX_LAST) begin
                    rsp_opcode_d = '0;
                    rsp_hit_d    = 1'b0;
                    state_d      = RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                // Scan results settle for one cycle before rsp_valid is raised; rsp_ready
                // only counts once the consumer can actually see rsp_valid.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight request without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            word_q       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_opcode_q <= '0;
            rsp_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_hit_q    <= rsp_hit_d;
        end
    end

`ifdef ALU_CTRL_ENC_LASTHIT_EN
    // Last-hit cache; only scan hits are ever written, so a cached entry is always a real match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q  <= 1'b0;
            cache_ctrl_q <= '0;
            cache_opc_q  <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_ctrl_q <= cache_ctrl_d;
            cache_opc_q  <= cache_opc_d;
        end
    end
`endif

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_opcode = rsp_opcode_q;
    assign rsp_hit    = rsp_hit_q;

endmodule
